uart_bridge: RTL and testbench

Byte-level command responder that sits behind the UART byte engine and lets an external host read and write the internal bus. It decodes `'W'` (write) and `'R'` (read) frames from the received byte stream, issues one single-beat bus transfer per frame, and returns a response frame on the transmit byte stream.

---
 rtl/uart_bridge.sv | 114 +++++++++++
 tb/tb_uart_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bridge.sv
// uart_bridge: decodes 'W'/'R' command frames from a UART byte stream into single-beat bus transfers and returns response frames
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i   : received byte stream, no backpressure
//   tx_data_o, tx_valid_o,
//   tx_ready_i              : response byte stream, valid/ready handshake
//   req_o, we_o, addr_o,
//   wdata_o, rdata_i, ack_i : single-beat bus master
//   busy_o, overrun_o,
//   timeout_o               : status flags
module uart_bridge #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  state_t        r_state;
  logic          r_wr;
  logic [1:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_shift;
  logic [2:0]    r_len;
  logic [TW-1:0] r_tmo;
  logic          r_overrun;
  logic          r_timeout;
  logic          w_rx_phase;
  logic          w_tmo_hit;
  // the abort fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES
  assign w_rx_phase = (r_state == ADDR) || (r_state == DATA);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1)) && !rx_valid_i;
  assign req_o      = r_state == BUS;
  assign we_o       = req_o && r_wr;
  assign addr_o     = r_addr;
  assign wdata_o    = r_wdata;
  assign tx_valid_o = r_state == RESP;
  assign tx_data_o  = r_shift[7:0];
  assign busy_o     = r_state != IDLE;
  assign overrun_o  = r_overrun;
  assign timeout_o  = r_timeout;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_cnt     <= 2'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_shift   <= 32'd0;
      r_len     <= 3'd0;
      r_tmo     <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_overrun <= rx_valid_i && (r_state == BUS || r_state == RESP);
      r_timeout <= 1'b0;
      r_tmo     <= (w_rx_phase && !rx_valid_i) ? r_tmo + TW'(1) : '0;
      case (r_state)
        IDLE: if (rx_valid_i) begin
          if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
            r_wr    <= rx_data_i == 8'h57;
            r_cnt   <= 2'd0;
            r_state <= ADDR;
          end else begin
            r_shift <= 32'h0000_003F;
            r_len   <= 3'd1;
            r_state <= RESP;
          end
        end
        ADDR: if (rx_valid_i) begin
          r_addr[8*r_cnt +: 8] <= rx_data_i;
          r_cnt                <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= r_wr ? DATA : BUS;
        end else if (w_tmo_hit) begin
          r_state   <= IDLE;
          r_timeout <= 1'b1;
        end
        DATA: if (rx_valid_i) begin
          r_wdata[8*r_cnt +: 8] <= rx_data_i;
          r_cnt                 <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= BUS;
        end else if (w_tmo_hit) begin
          r_state   <= IDLE;
          r_timeout <= 1'b1;
        end
        BUS: if (ack_i) begin
          r_shift <= r_wr ? 32'h0000_004B : rdata_i;
          r_len   <= r_wr ? 3'd1 : 3'd4;
          r_state <= RESP;
        end
        RESP: if (tx_ready_i) begin
          r_shift <= r_shift >> 8;
          r_len   <= r_len - 3'd1;
          if (r_len == 3'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bridge.sv
// tb_uart_bridge: randomized scoreboard bench for uart_bridge
module tb_uart_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic        ack = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        overrun_o;
  logic        timeout_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;
  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  bit          rdy_rand = 1'b0;
  bit          hold_ack = 1'b0;
  int          ack_delay = 0;
  int          age = 0;
  logic [31:0] next_rdata = 32'h0;
  int          n_overrun = 0;
  int          n_timeout = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_d = 8'h00;
  bit          ack_seen = 1'b0;
  always #5 clk = ~clk;
  uart_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata), .ack_i(ack), .busy_o(busy_o), .overrun_o(overrun_o),
    .timeout_o(timeout_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(posedge clk);
    #1;
    ack = 1'b0;
    if (!req_o) age = 0;
    else begin
      if (!hold_ack && age >= ack_delay) begin
        ack   = 1'b1;
        rdata = next_rdata;
      end
      age++;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      ack_seen = 1'b0;
    end else begin
      if (tx_valid_o) begin
        if (pend) chk("tx_stable", {24'h0, tx_data_o}, {24'h0, pend_d});
        if (tx_ready) begin
          if (tx_q.size() == 0) unexpected("tx_byte", {24'h0, tx_data_o});
          else chk("tx_byte", {24'h0, tx_data_o}, {24'h0, tx_q.pop_front()});
        end
      end
      pend   = tx_valid_o && !tx_ready;
      pend_d = tx_data_o;
      if (ack_seen) begin
        chk("req_drop", {31'h0, req_o}, 32'h0);
        chk("tx_after_ack", {31'h0, tx_valid_o}, 32'h1);
      end
      ack_seen = 1'b0;
      if (req_o && ack) begin
        ack_seen = 1'b1;
        if (bus_q.size() == 0) unexpected("bus_xfer", addr_o);
        else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_we", {31'h0, we_o}, {31'h0, e.we});
          chk("bus_addr", addr_o, e.addr);
          if (e.we) chk("bus_wdata", wdata_o, e.wdata);
        end
      end
      if (overrun_o) n_overrun++;
      if (timeout_o) n_timeout++;
    end
  end
  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rd, input bit rgap);
    logic [7:0] bytes[$];
    next_rdata = rd;
    bytes.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
    if (cmd == 8'h57) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
    if (cmd == 8'h57) begin
      bus_q.push_back('{1'b1, addr, data});
      tx_q.push_back(8'h4B);
    end else if (cmd == 8'h52) begin
      bus_q.push_back('{1'b0, addr, 32'h0});
      for (int i = 0; i < 4; i++) tx_q.push_back(rd[8*i +: 8]);
    end else tx_q.push_back(8'h3F);
    foreach (bytes[i]) send(bytes[i], (rgap && i != bytes.size() - 1) ? int'($urandom_range(0, 2)) : 0);
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o || tx_q.size() != 0 || bus_q.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n < 400), 32'h1);
  endtask
  task automatic wait_req(input string name);
    int n = 0;
    while (!req_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {31'h0, req_o}, 32'h1);
  endtask
  initial begin
    int hit;
    logic [7:0] c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, req_o}, 32'h0);
    chk("rst_txv", {31'h0, tx_valid_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_flags", {30'h0, overrun_o, timeout_o}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ack_delay = 3;
    run_frame(8'h57, 32'h4000_0010, 32'hDEAD_BEEF, $urandom, 1'b0);
    chk("wr_req_latency", {31'h0, req_o}, 32'h1);
    chk("wr_we", {31'h0, we_o}, 32'h1);
    wait_idle("wr_done");
    rdy_rand  = 1'b1;
    ack_delay = 0;
    run_frame(8'h52, 32'h4000_0004, 32'h0, 32'h1234_5678, 1'b0);
    chk("rd_req_latency", {31'h0, req_o}, 32'h1);
    wait_idle("rd_done");
    rdy_rand = 1'b0;
    run_frame(8'h41, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("bad_txv", {31'h0, tx_valid_o}, 32'h1);
    chk("bad_req", {31'h0, req_o}, 32'h0);
    wait_idle("bad_done");
    run_frame(8'h52, $urandom, 32'h0, $urandom, 1'b1);
    wait_idle("rd2_done");
    send(8'h57, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    hit = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (timeout_o && hit == 0) hit = i;
    end
    chk("tmo_cycle", 32'(hit), 32'd9);
    chk("tmo_idle", {31'h0, busy_o}, 32'h0);
    @(posedge clk);
    #1;
    run_frame(8'h52, 32'h0, 32'h0, $urandom, 1'b0);
    wait_idle("tmo_rd_done");
    hold_ack = 1'b1;
    run_frame(8'h52, $urandom, 32'h0, $urandom, 1'b0);
    wait_req("ovr_req");
    send(8'h55, 0);
    @(negedge clk);
    chk("ovr_pulse", {31'h0, overrun_o}, 32'h1);
    @(negedge clk);
    chk("ovr_once", {31'h0, overrun_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("ovr_req_held", {31'h0, req_o}, 32'h1);
    hold_ack = 1'b0;
    wait_idle("ovr_done");
    hold_ack = 1'b1;
    run_frame(8'h57, $urandom, $urandom, $urandom, 1'b0);
    wait_req("rst_mid_req");
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_req", {31'h0, req_o}, 32'h0);
    chk("rstm_txv", {31'h0, tx_valid_o}, 32'h0);
    chk("rstm_busy", {31'h0, busy_o}, 32'h0);
    chk("rstm_addr", addr_o, 32'h0);
    bus_q.delete();
    tx_q.delete();
    hold_ack = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8'h57, $urandom, $urandom, $urandom, 1'b0);
    wait_idle("rst_wr_done");
    rdy_rand = 1'b1;
    repeat (40) begin
      ack_delay = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0: c = 8'h57;
        1: c = 8'h52;
        default: begin
          c = 8'($urandom_range(0, 255));
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom_range(0, 255));
        end
      endcase
      run_frame(c, $urandom, $urandom, $urandom, 1'b1);
      wait_idle("rand_done");
    end
    chk("overrun_count", 32'(n_overrun), 32'd1);
    chk("timeout_count", 32'(n_timeout), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
